// File: rtl/uart_cmd_system_if.sv
// rtl/uart_cmd_system_if.sv - serial line and status bundle of the UART command processor
interface uart_cmd_system_if;
   logic serial_data_in;
   logic serial_data_out;
   logic parity_error;
   logic frame_error;
   logic transmitter_busy;

   modport master (
      output serial_data_in,
      input  serial_data_out, parity_error, frame_error, transmitter_busy
   );
   modport slave (
      input  serial_data_in,
      output serial_data_out, parity_error, frame_error, transmitter_busy
   );
endinterface

// File: rtl/uart_cmd_system.sv
// rtl/uart_cmd_system.sv - UART command processor: RX, control FSM, register file, ALU, TX
module uart_cmd_system #(
   parameter int DATA_WIDTH               = 8,
   parameter int REGISTER_FILE_DEPTH      = 16,
   parameter int PRESCALE                 = 8,
   parameter int SYNCHRONIZER_STAGE_COUNT = 2
) (
   input logic              reference_clk,
   input logic              reset,
   uart_cmd_system_if.slave uart
);
   localparam int CW = $clog2(PRESCALE);
   localparam int AW = $clog2(REGISTER_FILE_DEPTH);
   localparam int FW = DATA_WIDTH + 3;
   localparam int BW = $clog2(FW);
   localparam int RW = 2 * DATA_WIDTH;
   localparam logic [BW-1:0] PAR_BIT  = BW'(FW - 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
   localparam logic [CW-1:0] MID_CNT  = CW'(PRESCALE / 2);
   localparam logic [CW-1:0] END_CNT  = CW'(PRESCALE - 1);
   localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_RUN = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, ALU_EXEC, TX_BYTE0, TX_BYTE1
   } state_t;

   logic [SYNCHRONIZER_STAGE_COUNT-1:0] sync_q;
   logic                  rx_s, rx_prev_q;
   logic                  rx_active_q, rx_active_d;
   logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]         rx_bit_q, rx_bit_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic                  rx_par_q, rx_par_d;
   logic                  par_err_q, par_err_d, frm_err_q, frm_err_d;
   logic                  rx_valid;

   logic                  tx_busy_q, tx_busy_d;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]         tx_bit_q, tx_bit_d;
   logic [FW-1:0]         tx_frame_q, tx_frame_d;
   logic                  tx_start, tx_done;
   logic [DATA_WIDTH-1:0] tx_data;

   state_t                state_q, state_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [3:0]            func_q, func_d;
   logic [RW-1:0]         result_q, result_d, alu_res;
   logic [DATA_WIDTH-1:0] regs_q [REGISTER_FILE_DEPTH];
   logic                  reg_we;
   logic [AW-1:0]         reg_waddr;
   logic [DATA_WIDTH-1:0] op_a, op_b;

   assign rx_s = sync_q[SYNCHRONIZER_STAGE_COUNT-1];

   // Every bit is sampled MID_CNT cycles after its nominal start; the start bit doubles as glitch filter.
   always_comb begin
      rx_active_d = rx_active_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_par_d    = rx_par_q;
      par_err_d   = par_err_q;
      frm_err_d   = frm_err_q;
      rx_valid    = 1'b0;
      if (!rx_active_q) begin
         if (rx_prev_q && !rx_s) begin
            rx_active_d = 1'b1;
            rx_cnt_d    = CW'(1);
            rx_bit_d    = '0;
         end
      end else begin
         rx_cnt_d = (rx_cnt_q == END_CNT) ? '0 : rx_cnt_q + 1'b1;
         if (rx_cnt_q == END_CNT) rx_bit_d = rx_bit_q + 1'b1;
         if (rx_cnt_q == MID_CNT) begin
            if (rx_bit_q == '0) begin
               if (rx_s) rx_active_d = 1'b0;
            end else if (rx_bit_q == PAR_BIT) begin
               rx_par_d = rx_s;
            end else if (rx_bit_q == LAST_BIT) begin
               rx_active_d = 1'b0;
               par_err_d   = rx_par_q ^ (^rx_shift_q);
               frm_err_d   = !rx_s;
               rx_valid    = (rx_par_q == (^rx_shift_q)) && rx_s;
            end else begin
               rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
            end
         end
      end
   end

   assign tx_done = tx_busy_q && (tx_cnt_q == END_CNT) && (tx_bit_q == LAST_BIT);

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_frame_d = tx_frame_q;
      if (!tx_busy_q) begin
         if (tx_start) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_frame_d = {1'b1, ^tx_data, tx_data, 1'b0};
         end
      end else if (tx_cnt_q == END_CNT) begin
         tx_cnt_d = '0;
         if (tx_done) begin
            tx_busy_d = 1'b0;
         end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_frame_d = {1'b1, tx_frame_q[FW-1:1]};
         end
      end else begin
         tx_cnt_d = tx_cnt_q + 1'b1;
      end
   end

   assign op_a = regs_q[0];
   assign op_b = regs_q[1];

   always_comb begin
      alu_res = '0;
      case (func_q)
         4'h0:    alu_res = {{DATA_WIDTH{1'b0}}, op_a} + {{DATA_WIDTH{1'b0}}, op_b};
         4'h1:    alu_res = {{DATA_WIDTH{1'b0}}, op_a} - {{DATA_WIDTH{1'b0}}, op_b};
         4'h2:    alu_res = {{DATA_WIDTH{1'b0}}, op_a} * {{DATA_WIDTH{1'b0}}, op_b};
         4'h3:    alu_res = (op_b == '0) ? '0 : {{DATA_WIDTH{1'b0}}, op_a / op_b};
         4'h4:    alu_res = {{DATA_WIDTH{1'b0}}, op_a & op_b};
         4'h5:    alu_res = {{DATA_WIDTH{1'b0}}, op_a | op_b};
         4'h6:    alu_res = {{DATA_WIDTH{1'b0}}, ~(op_a & op_b)};
         4'h7:    alu_res = {{DATA_WIDTH{1'b0}}, ~(op_a | op_b)};
         4'h8:    alu_res = {{DATA_WIDTH{1'b0}}, op_a ^ op_b};
         4'h9:    alu_res = {{DATA_WIDTH{1'b0}}, ~(op_a ^ op_b)};
         4'hA:    alu_res = (op_a == op_b) ? RW'(1) : '0;
         4'hB:    alu_res = (op_a > op_b) ? RW'(2) : '0;
         4'hC:    alu_res = (op_a < op_b) ? RW'(3) : '0;
         4'hD:    alu_res = {{DATA_WIDTH{1'b0}}, op_a >> 1};
         4'hE:    alu_res = {{DATA_WIDTH{1'b0}}, op_a} << 1;
         default: alu_res = '0;
      endcase
   end

   // A read parks its byte in the upper result half so TX_BYTE1 serves both reads and ALU high bytes.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      func_d    = func_q;
      result_d  = result_q;
      reg_we    = 1'b0;
      reg_waddr = addr_q;
      tx_start  = 1'b0;
      tx_data   = result_q[DATA_WIDTH-1:0];
      case (state_q)
         IDLE: if (rx_valid) begin
            if (rx_shift_q == CMD_WR)       state_d = WR_ADDR;
            else if (rx_shift_q == CMD_RD)  state_d = RD_ADDR;
            else if (rx_shift_q == CMD_ALU) state_d = ALU_A;
            else if (rx_shift_q == CMD_RUN) state_d = ALU_FUNC;
         end
         WR_ADDR: if (rx_valid) begin
            addr_d  = rx_shift_q[AW-1:0];
            state_d = WR_DATA;
         end
         WR_DATA: if (rx_valid) begin
            reg_we  = 1'b1;
            state_d = IDLE;
         end
         RD_ADDR: if (rx_valid) begin
            result_d = {regs_q[rx_shift_q[AW-1:0]], {DATA_WIDTH{1'b0}}};
            state_d  = TX_BYTE1;
         end
         ALU_A: if (rx_valid) begin
            reg_we    = 1'b1;
            reg_waddr = '0;
            state_d   = ALU_B;
         end
         ALU_B: if (rx_valid) begin
            reg_we    = 1'b1;
            reg_waddr = AW'(1);
            state_d   = ALU_FUNC;
         end
         ALU_FUNC: if (rx_valid) begin
            func_d  = rx_shift_q[3:0];
            state_d = ALU_EXEC;
         end
         ALU_EXEC: begin
            result_d = alu_res;
            state_d  = TX_BYTE0;
         end
         TX_BYTE0: begin
            if (tx_done)         state_d  = TX_BYTE1;
            else if (!tx_busy_q) tx_start = 1'b1;
         end
         TX_BYTE1: begin
            tx_data = result_q[RW-1:DATA_WIDTH];
            if (tx_done)         state_d  = IDLE;
            else if (!tx_busy_q) tx_start = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge reference_clk) begin
      if (reset) begin
         sync_q      <= '1;
         rx_prev_q   <= 1'b1;
         rx_active_q <= 1'b0;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_par_q    <= 1'b0;
         par_err_q   <= 1'b0;
         frm_err_q   <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_frame_q  <= '1;
         state_q     <= IDLE;
         addr_q      <= '0;
         func_q      <= '0;
         result_q    <= '0;
         for (int i = 0; i < REGISTER_FILE_DEPTH; i++) regs_q[i] <= '0;
      end else begin
         sync_q      <= {sync_q[SYNCHRONIZER_STAGE_COUNT-2:0], uart.serial_data_in};
         rx_prev_q   <= rx_s;
         rx_active_q <= rx_active_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_par_q    <= rx_par_d;
         par_err_q   <= par_err_d;
         frm_err_q   <= frm_err_d;
         tx_busy_q   <= tx_busy_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_frame_q  <= tx_frame_d;
         state_q     <= state_d;
         addr_q      <= addr_d;
         func_q      <= func_d;
         result_q    <= result_d;
         if (reg_we) regs_q[reg_waddr] <= rx_shift_q;
      end
   end

   assign uart.serial_data_out  = tx_busy_q ? tx_frame_q[0] : 1'b1;
   assign uart.transmitter_busy = tx_busy_q;
   assign uart.parity_error     = par_err_q;
   assign uart.frame_error      = frm_err_q;
endmodule

// File: tb/tb_uart_cmd_system.sv
// tb/tb_uart_cmd_system.sv - scoreboard bench for the UART command processor
`timescale 1ns/1ps
module tb_uart_cmd_system;
   localparam int P = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_cmd_system_if bus ();

   uart_cmd_system #(
      .DATA_WIDTH(8),
      .REGISTER_FILE_DEPTH(16),
      .PRESCALE(P),
      .SYNCHRONIZER_STAGE_COUNT(2)
   ) dut (
      .reference_clk(clk),
      .reset(rst),
      .uart(bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          exp_rises = 0;
   int          busy_rises = 0;
   bit          abort_flag = 1'b0;
   logic [10:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         bus.serial_data_in = f[i];
         repeat (P) @(negedge clk);
      end
      bus.serial_data_in = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      send_byte(d, 1'b0, 1'b0);
   endtask

   task automatic expect_frame(input logic [7:0] d);
      exp_q.push_back({1'b1, ^d, d, 1'b0});
      exp_rises++;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.transmitter_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_in_time"}, 32'(n < 3000), 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic pb;
      pb = 1'b0;
      forever begin
         @(negedge clk);
         if (!pb && bus.transmitter_busy === 1'b1) busy_rises++;
         pb = (bus.transmitter_busy === 1'b1);
      end
   end

   // Frame decoder: samples each bit at its middle and pops the oldest expected frame.
   initial begin
      logic        prev;
      logic [10:0] got;
      logic        busy_ok;
      logic [10:0] exp;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && bus.serial_data_out === 1'b0 && !rst) begin
            busy_ok = 1'b1;
            repeat (P / 2) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
               got[i]  = bus.serial_data_out;
               busy_ok = busy_ok & (bus.transmitter_busy === 1'b1);
               if (i < 10) repeat (P) @(negedge clk);
            end
            if (abort_flag) begin
               abort_flag = 1'b0;
            end else if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: got %0h expected no frame", got);
            end else begin
               exp = exp_q.pop_front();
               check("tx_frame", 32'(got), 32'(exp));
               check("busy_during_frame", 32'(busy_ok), 1);
            end
         end
         prev = bus.serial_data_out;
      end
   end

   initial begin
      int n;
      bus.serial_data_in = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (8 * P) @(negedge clk);
      check("reset_sdo", 32'(bus.serial_data_out), 1);
      check("reset_busy", 32'(bus.transmitter_busy), 0);
      check("reset_perr", 32'(bus.parity_error), 0);
      check("reset_ferr", 32'(bus.frame_error), 0);

      send(8'hAA); send(8'h05); send(8'h3C);
      expect_frame(8'h3C);
      send(8'hBB); send(8'h05);
      wait_drain("read_3c");

      expect_frame(8'h1E); expect_frame(8'h00);
      send(8'hCC); send(8'h0A); send(8'h03); send(8'h02);
      wait_drain("alu_mul");

      expect_frame(8'h0D); expect_frame(8'h00);
      send(8'hDD); send(8'h00);
      wait_drain("alu_add");

      send(8'hAA); send(8'h01); send(8'h00);
      expect_frame(8'h00); expect_frame(8'h00);
      send(8'hDD); send(8'h03);
      wait_drain("alu_div0");

      send_byte(8'hAA, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      check("bad_parity_perr", 32'(bus.parity_error), 1);
      check("bad_parity_ferr", 32'(bus.frame_error), 0);
      send_byte(8'h55, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("bad_stop_ferr", 32'(bus.frame_error), 1);
      check("bad_stop_perr", 32'(bus.parity_error), 0);
      expect_frame(8'h3C);
      send(8'hBB); send(8'h05);
      wait_drain("read_after_errors");
      check("cleared_perr", 32'(bus.parity_error), 0);
      check("cleared_ferr", 32'(bus.frame_error), 0);

      send(8'hBB); send(8'h05);
      n = 0;
      while (bus.transmitter_busy !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("abort_tx_started", 32'(n < 500), 1);
      repeat (30) @(negedge clk);
      abort_flag = 1'b1;
      exp_rises++;
      rst = 1'b1;
      @(negedge clk);
      check("abort_sdo", 32'(bus.serial_data_out), 1);
      check("abort_busy", 32'(bus.transmitter_busy), 0);
      rst = 1'b0;
      repeat (8 * P) @(negedge clk);
      expect_frame(8'h00);
      send(8'hBB); send(8'h05);
      wait_drain("read_after_reset");

      check("busy_rise_count", 32'(busy_rises), 32'(exp_rises));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
